// File: rtl/odd_rf_fwd.sv
// odd_rf_fwd: odd-pipe operand fetch with a 128x128 register file, writeback bypass
// and forwarding from the staging stages of both pipes, plus hazard stall.
module odd_rf_fwd (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [10:0]            in_op,
    input  logic [2:0]             in_format,
    input  logic [1:0]             in_unit,
    input  logic [6:0]             in_rt_addr,
    input  logic [6:0]             in_ra_addr,
    input  logic [6:0]             in_rb_addr,
    input  logic [17:0]            in_imm,
    input  logic                   in_reg_write,
    input  logic [127:0]           ev_wb_data,
    input  logic [6:0]             ev_wb_addr,
    input  logic                   ev_wb_write,
    input  logic [127:0]           od_wb_data,
    input  logic [6:0]             od_wb_addr,
    input  logic                   od_wb_write,
    input  logic [6:0][127:0]      ev_fw_data,
    input  logic [6:0][6:0]        ev_fw_addr,
    input  logic [6:0]             ev_fw_write,
    input  logic [6:0]             ev_fw_ready,
    input  logic [6:0][127:0]      od_fw_data,
    input  logic [6:0][6:0]        od_fw_addr,
    input  logic [6:0]             od_fw_write,
    input  logic [6:0]             od_fw_ready,
    output logic [10:0]            op,
    output logic [2:0]             format,
    output logic [1:0]             unit,
    output logic [6:0]             rt_addr,
    output logic [127:0]           ra,
    output logic [127:0]           rb,
    output logic [17:0]            imm,
    output logic                   reg_write,
    output logic                   out_valid,
    output logic                   stall
);
    localparam logic [2:0] FMT_RR = 3'd1, FMT_RI = 3'd2, FMT_RI16 = 3'd3, FMT_RI18 = 3'd4;

    typedef struct packed {
        logic [10:0]  op;
        logic [2:0]   format;
        logic [1:0]   unit;
        logic [6:0]   rt_addr;
        logic [127:0] ra;
        logic [127:0] rb;
        logic [17:0]  imm;
        logic         reg_write;
        logic         valid;
    } issue_t;

    logic [127:0]       rf_q [128];
    logic [127:0]       rf_d [128];
    logic [1:0][6:0]    src_addr;
    logic [1:0]         fw_hit, fw_rdy, haz;
    logic [1:0][127:0]  fw_data, opnd;
    logic               use_ra, use_rb, fire;
    issue_t             issue_d, issue_q;

    // odd writeback is applied last so it wins a same-address collision
    always_comb begin
        rf_d = rf_q;
        if (ev_wb_write) rf_d[ev_wb_addr] = ev_wb_data;
        if (od_wb_write) rf_d[od_wb_addr] = od_wb_data;
    end

    always_ff @(posedge clk)
        for (int i = 0; i < 128; i++) rf_q[i] <= reset ? '0 : rf_d[i];

    assign src_addr = {in_rb_addr, in_ra_addr};

    // scan oldest to youngest so the youngest match overwrites; odd after even at each stage
    always_comb begin
        fw_hit  = '0;
        fw_rdy  = '0;
        fw_data = '0;
        opnd    = '0;
        haz     = '0;
        for (int k = 0; k < 2; k++) begin
            for (int s = 6; s >= 0; s--) begin
                if (ev_fw_write[s] && ev_fw_addr[s] == src_addr[k]) begin
                    fw_hit[k]  = 1'b1;
                    fw_rdy[k]  = ev_fw_ready[s];
                    fw_data[k] = ev_fw_data[s];
                end
                if (od_fw_write[s] && od_fw_addr[s] == src_addr[k]) begin
                    fw_hit[k]  = 1'b1;
                    fw_rdy[k]  = od_fw_ready[s];
                    fw_data[k] = od_fw_data[s];
                end
            end
            opnd[k] = fw_hit[k] ? fw_data[k] :
                      (od_wb_write && od_wb_addr == src_addr[k]) ? od_wb_data :
                      (ev_wb_write && ev_wb_addr == src_addr[k]) ? ev_wb_data :
                      rf_q[src_addr[k]];
            haz[k] = fw_hit[k] & ~fw_rdy[k];
        end
    end

    assign use_ra = in_format inside {FMT_RR, FMT_RI, FMT_RI16, FMT_RI18};
    assign use_rb = in_format == FMT_RR;
    assign stall  = !reset && in_valid && ((use_ra && haz[0]) || (use_rb && haz[1]));
    assign fire   = in_valid && !stall;

    always_comb begin
        issue_d = '0;
        if (fire) begin
            issue_d.op        = in_op;
            issue_d.format    = in_format;
            issue_d.unit      = in_unit;
            issue_d.rt_addr   = in_rt_addr;
            issue_d.ra        = opnd[0];
            issue_d.rb        = opnd[1];
            issue_d.imm       = in_imm;
            issue_d.reg_write = in_reg_write;
            issue_d.valid     = 1'b1;
        end
    end

    always_ff @(posedge clk)
        issue_q <= reset ? '0 : issue_d;

    assign op        = issue_q.op;
    assign format    = issue_q.format;
    assign unit      = issue_q.unit;
    assign rt_addr   = issue_q.rt_addr;
    assign ra        = issue_q.ra;
    assign rb        = issue_q.rb;
    assign imm       = issue_q.imm;
    assign reg_write = issue_q.reg_write;
    assign out_valid = issue_q.valid;
endmodule

// File: tb/tb_odd_rf_fwd.sv
// tb_odd_rf_fwd: directed vectors; expected issues are queued at drive time and a
// monitor pops and compares them whenever out_valid appears.
module tb_odd_rf_fwd;
    localparam logic [2:0] F_NONE = 3'd0, F_RR = 3'd1, F_RI = 3'd2;
    localparam logic [127:0] R5 = {16{8'h11}};
    localparam logic [127:0] VA = {4{32'hAAAA_0001}}, VB = {4{32'hBBBB_0002}};
    localparam logic [127:0] VC = {4{32'hCCCC_0003}}, VD = {4{32'hDDDD_0004}};
    localparam logic [127:0] VE = {4{32'hEEEE_0005}}, VF = {4{32'hFFFF_0006}};
    localparam logic [127:0] VG = {4{32'h1234_0007}}, VH = {4{32'h5678_0008}};

    logic clk = 1'b0, reset = 1'b1;
    logic in_valid, in_reg_write;
    logic [10:0] in_op;
    logic [2:0] in_format;
    logic [1:0] in_unit;
    logic [6:0] in_rt_addr, in_ra_addr, in_rb_addr;
    logic [17:0] in_imm;
    logic [127:0] ev_wb_data, od_wb_data;
    logic [6:0] ev_wb_addr, od_wb_addr;
    logic ev_wb_write, od_wb_write;
    logic [6:0][127:0] ev_fw_data, od_fw_data;
    logic [6:0][6:0] ev_fw_addr, od_fw_addr;
    logic [6:0] ev_fw_write, ev_fw_ready, od_fw_write, od_fw_ready;
    logic [10:0] op;
    logic [2:0] format;
    logic [1:0] unit;
    logic [6:0] rt_addr;
    logic [127:0] ra, rb;
    logic [17:0] imm;
    logic reg_write, out_valid, stall;

    odd_rf_fwd dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_format(in_format),
        .in_unit(in_unit), .in_rt_addr(in_rt_addr), .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
        .in_imm(in_imm), .in_reg_write(in_reg_write),
        .ev_wb_data(ev_wb_data), .ev_wb_addr(ev_wb_addr), .ev_wb_write(ev_wb_write),
        .od_wb_data(od_wb_data), .od_wb_addr(od_wb_addr), .od_wb_write(od_wb_write),
        .ev_fw_data(ev_fw_data), .ev_fw_addr(ev_fw_addr), .ev_fw_write(ev_fw_write), .ev_fw_ready(ev_fw_ready),
        .od_fw_data(od_fw_data), .od_fw_addr(od_fw_addr), .od_fw_write(od_fw_write), .od_fw_ready(od_fw_ready),
        .op(op), .format(format), .unit(unit), .rt_addr(rt_addr), .ra(ra), .rb(rb), .imm(imm),
        .reg_write(reg_write), .out_valid(out_valid), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0]  op;
        logic [2:0]   fmt;
        logic [1:0]   unit;
        logic [6:0]   rt;
        logic [127:0] ra;
        logic [127:0] rb;
        logic [17:0]  imm;
        logic         rw;
        logic         ra_dc;
        logic         rb_dc;
    } exp_t;

    exp_t sb[$];
    int errors = 0, checks = 0, tag = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr;
        in_valid = 0; in_op = '0; in_format = '0; in_unit = '0; in_rt_addr = '0;
        in_ra_addr = '0; in_rb_addr = '0; in_imm = '0; in_reg_write = 0;
        ev_wb_data = '0; ev_wb_addr = '0; ev_wb_write = 0;
        od_wb_data = '0; od_wb_addr = '0; od_wb_write = 0;
        ev_fw_data = '0; ev_fw_addr = '0; ev_fw_write = '0; ev_fw_ready = '0;
        od_fw_data = '0; od_fw_addr = '0; od_fw_write = '0; od_fw_ready = '0;
    endtask

    task automatic set_instr(input logic [2:0] fmt, input logic [1:0] un, input logic [6:0] a, input logic [6:0] b);
        tag++;
        in_valid = 1; in_op = 11'(tag * 37 + 1); in_format = fmt; in_unit = un;
        in_rt_addr = 7'(tag + 40); in_ra_addr = a; in_rb_addr = b;
        in_imm = 18'(tag * 1001); in_reg_write = 1;
    endtask

    task automatic expect_issue(input logic [127:0] era, input logic [127:0] erb, input logic ra_dc, input logic rb_dc);
        sb.push_back('{in_op, in_format, in_unit, in_rt_addr, era, erb, in_imm, in_reg_write, ra_dc, rb_dc});
    endtask

    task automatic chk_bubble(input string name);
        @(posedge clk); #1;
        chk({name, "_valid"}, 128'(out_valid), 128'd0);
        chk({name, "_rw"}, 128'(reg_write), 128'd0);
        chk({name, "_op"}, 128'(op), 128'd0);
        chk({name, "_rt"}, 128'(rt_addr), 128'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: got out_valid=1 op=%h expected no issue", op);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("iss_op", 128'(op), 128'(e.op));
                    chk("iss_fmt", 128'(format), 128'(e.fmt));
                    chk("iss_unit", 128'(unit), 128'(e.unit));
                    chk("iss_rt", 128'(rt_addr), 128'(e.rt));
                    if (!e.ra_dc) chk("iss_ra", ra, e.ra);
                    if (!e.rb_dc) chk("iss_rb", rb, e.rb);
                    chk("iss_imm", 128'(imm), 128'(e.imm));
                    chk("iss_rw", 128'(reg_write), 128'(e.rw));
                end
            end
        end
    end

    initial begin
        clr();
        reset = 1;
        set_instr(F_RR, 2'd0, 7'd5, 7'd6);
        od_fw_write[0] = 1; od_fw_addr[0] = 7'd6;
        #1 chk("rst_stall", 128'(stall), 128'd0);
        chk_bubble("rst_out");
        @(negedge clk);
        reset = 0; clr();
        od_wb_write = 1; od_wb_addr = 7'd5; od_wb_data = R5;
        chk_bubble("post_rst");
        @(negedge clk);
        clr(); set_instr(F_RR, 2'd0, 7'd5, 7'd6); expect_issue(R5, '0, 0, 0);
        #1 chk("rr_stall", 128'(stall), 128'd0);
        @(negedge clk);
        clr(); ev_wb_write = 1; ev_wb_addr = 7'd9; ev_wb_data = VA;
        od_wb_write = 1; od_wb_addr = 7'd9; od_wb_data = VB;
        set_instr(F_RI, 2'd1, 7'd9, 7'd0); expect_issue(VB, '0, 0, 1);
        @(negedge clk);
        clr(); set_instr(F_RR, 2'd0, 7'd9, 7'd9); expect_issue(VB, VB, 0, 0);
        @(negedge clk);
        clr(); od_fw_write[1] = 1; od_fw_addr[1] = 7'd3; od_fw_ready[1] = 1; od_fw_data[1] = VC;
        ev_fw_write[1] = 1; ev_fw_addr[1] = 7'd3; ev_fw_ready[1] = 1; ev_fw_data[1] = VD;
        set_instr(F_RR, 2'd2, 7'd3, 7'd3); expect_issue(VC, VC, 0, 0);
        @(negedge clk);
        ev_fw_write[0] = 1; ev_fw_addr[0] = 7'd3; ev_fw_ready[0] = 1; ev_fw_data[0] = VE;
        set_instr(F_RR, 2'd3, 7'd3, 7'd5); expect_issue(VE, R5, 0, 0);
        @(negedge clk);
        clr(); ev_fw_write[6] = 1; ev_fw_addr[6] = 7'd20; ev_fw_ready[6] = 1; ev_fw_data[6] = VH;
        set_instr(F_RR, 2'd0, 7'd20, 7'd5); expect_issue(VH, R5, 0, 0);
        @(negedge clk);
        clr(); od_fw_write[2] = 1; od_fw_addr[2] = 7'd30; od_fw_ready[2] = 0; od_fw_data[2] = VA;
        ev_fw_write[1] = 1; ev_fw_addr[1] = 7'd30; ev_fw_ready[1] = 1; ev_fw_data[1] = VD;
        set_instr(F_RR, 2'd1, 7'd30, 7'd5); expect_issue(VD, R5, 0, 0);
        #1 chk("young_ready_stall", 128'(stall), 128'd0);
        @(negedge clk);
        clr(); od_fw_write[0] = 1; od_fw_addr[0] = 7'd7; od_fw_ready[0] = 0; od_fw_data[0] = VF;
        od_wb_write = 1; od_wb_addr = 7'd12; od_wb_data = VG;
        set_instr(F_RR, 2'd0, 7'd5, 7'd7);
        #1 chk("haz_stall1", 128'(stall), 128'd1);
        chk_bubble("haz_bub1");
        @(negedge clk);
        od_wb_write = 0;
        #1 chk("haz_stall2", 128'(stall), 128'd1);
        chk_bubble("haz_bub2");
        @(negedge clk);
        od_fw_ready[0] = 1; expect_issue(R5, VF, 0, 0);
        #1 chk("haz_release", 128'(stall), 128'd0);
        @(negedge clk);
        od_fw_ready[0] = 0; set_instr(F_RI, 2'd2, 7'd5, 7'd7); expect_issue(R5, '0, 0, 1);
        #1 chk("ri_rb_haz_stall", 128'(stall), 128'd0);
        @(negedge clk);
        set_instr(F_RI, 2'd0, 7'd7, 7'd5);
        #1 chk("ri_ra_haz_stall", 128'(stall), 128'd1);
        chk_bubble("ri_ra_bub");
        @(negedge clk);
        set_instr(F_NONE, 2'd1, 7'd7, 7'd7); expect_issue('0, '0, 1, 1);
        #1 chk("fmt0_stall", 128'(stall), 128'd0);
        @(negedge clk);
        clr(); set_instr(F_RR, 2'd0, 7'd12, 7'd9); expect_issue(VG, VB, 0, 0);
        @(negedge clk);
        clr();
        chk_bubble("idle");
        @(negedge clk);
        od_fw_write[0] = 1; od_fw_addr[0] = 7'd7; od_fw_ready[0] = 0; od_fw_data[0] = VF;
        set_instr(F_RR, 2'd0, 7'd5, 7'd7);
        #1 chk("pre_rst_stall", 128'(stall), 128'd1);
        @(negedge clk);
        reset = 1;
        #1 chk("rst_forces_stall0", 128'(stall), 128'd0);
        @(posedge clk); #1;
        chk("rst2_valid", 128'(out_valid), 128'd0);
        chk("rst2_ra", ra, '0);
        chk("rst2_imm", 128'(imm), 128'd0);
        @(negedge clk);
        reset = 0; clr();
        set_instr(F_RR, 2'd0, 7'd5, 7'd9); expect_issue('0, '0, 0, 0);
        @(negedge clk);
        clr();
        repeat (3) @(negedge clk);
        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
